// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key-schedule slice.
package aes_pkg;

  localparam int Nb = 4;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  import aes_pkg::*;

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one schedule word per clock into a register
// file of Nr+1 round keys, read combinationally by round index.
module aes_key_schedule_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [Nk*32-1:0]  key,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk_out
);
  import aes_pkg::*;

  localparam int         W       = Nb * (Nr + 1);
  localparam logic [5:0] NK_W    = 6'(Nk);
  localparam logic [5:0] LAST_W  = 6'(W - 1);
  localparam logic [2:0] MOD_TOP = 3'(Nk - 1);

  state_t      state;
  logic [31:0] w [W];
  logic [5:0]  wi;        // index of the word written on the next EXPAND edge
  logic [2:0]  mod_cnt;   // zero exactly when wi mod Nk == 0
  logic [3:0]  rcon_idx;
  logic [31:0] prev_word, back_word, sub_in, sub_out, temp, new_word;
  logic        load, step;
  logic [5:0]  rk_base;

  assign load = (state == IDLE) && start;
  assign step = (state == EXPAND);

  assign prev_word = w[wi - 6'd1];
  assign back_word = w[wi - NK_W];

  // RotWord only applies on the Rcon step; the Nk=8 mid-key step uses plain SubWord.
  assign sub_in = (mod_cnt == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Select the temp word fed into the schedule recurrence.
  always_comb begin
    temp = prev_word;
    if (mod_cnt == 3'd0)
      temp = sub_out ^ {RCON[rcon_idx], 24'h0};
    else if ((Nk == 8) && (mod_cnt == 3'd4))
      temp = sub_out;
  end

  assign new_word = back_word ^ temp;

  // Control FSM: word counter, modulo down-counter, Rcon index and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      wi         <= '0;
      mod_cnt    <= '0;
      rcon_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= EXPAND;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            wi         <= NK_W;
            mod_cnt    <= '0;
            rcon_idx   <= '0;
          end
        end
        EXPAND: begin
          wi      <= wi + 6'd1;
          mod_cnt <= (mod_cnt == 3'd0) ? MOD_TOP : mod_cnt - 3'd1;
          if (mod_cnt == 3'd0)
            rcon_idx <= rcon_idx + 4'd1;
          if (wi == LAST_W) begin
            state      <= IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            done       <= 1'b1;
          end
        end
      endcase
    end
  end

  // Word register file: key capture on start, one decoded word write per EXPAND edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < W; j++)
        w[j] <= '0;
    end else if (load) begin
      for (int j = 0; j < Nk; j++)
        w[j] <= key[(Nk-j)*32-1 -: 32];
    end else if (step) begin
      for (int j = Nk; j < W; j++)
        if (wi == 6'(j))
          w[j] <= new_word;
    end
  end

  assign rk_base = {rk_idx, 2'b00};

  // Round-key read port; indices past Nr read as zero.
  always_comb begin
    rk_out = '0;
    if (rk_idx <= 4'(Nr))
      rk_out = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq (AES-128 and AES-256 instances).
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_a;
  logic         start_a, busy_a, done_a, kv_a;
  logic [3:0]   idx_a;
  logic [127:0] rk_a;
  logic [255:0] key_b;
  logic         start_b, busy_b, done_b, kv_b;
  logic [3:0]   idx_b;
  logic [127:0] rk_b;

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.Nk(4), .Nr(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .key(key_a), .start(start_a), .busy(busy_a),
    .done(done_a), .keys_valid(kv_a), .rk_idx(idx_a), .rk_out(rk_a)
  );

  aes_key_schedule_seq #(.Nk(8), .Nr(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .key(key_b), .start(start_b), .busy(busy_b),
    .done(done_b), .keys_valid(kv_b), .rk_idx(idx_b), .rk_out(rk_b)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           lat_q  [$];
  logic [127:0] rk_q   [$];
  int           done_q [$];
  logic [7:0]   sb_t  [256];
  logic [7:0]   isb_t [256];
  logic [31:0]  mw    [60];
  logic [127:0] dk    [11];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inverse plus affine transform.
  task automatic build_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_t[x] = b;
      isb_t[b] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    int wt;
    logic [7:0]  rc;
    logic [31:0] t;
    wt = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < wt; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // AES-128 inverse cipher using round keys held in dk[].
  task automatic inv_cipher(input logic [127:0] ct, output logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ dk[10][127-8*n -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = s[4*((c - rr + 4) % 4) + rr];
      for (int n = 0; n < 16; n++) s[n] = isb_t[t[n]] ^ dk[r][127-8*n -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end
    for (int n = 0; n < 16; n++) pt[127-8*n -: 8] = s[n];
  endtask

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic pulse_start_a(input logic [127:0] k);
    @(negedge clk);
    key_a = k; start_a = 1'b1;
    lat_q.push_back(40);
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (done_a !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic read_a(input logic [3:0] idx, output logic [127:0] v);
    @(negedge clk);
    idx_a = idx;
    #1 v = rk_a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    key_a = '0; key_b = '0; idx_a = 4'd0; idx_b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, kv_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b want 000", {busy_a, done_a, kv_a});
    end
    n_checks++;
    if ({busy_b, done_b, kv_b} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl_b: got %b want 000", {busy_b, done_b, kv_b});
    end
    n_checks++;
    if (rk_a !== 128'h0) begin n_fail++; $display("FAIL reset_rk_a: got %h want 0", rk_a); end
    n_checks++;
    if (rk_b !== 128'h0) begin n_fail++; $display("FAIL reset_rk_b: got %h want 0", rk_b); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fips128();
    int n, e;
    logic [127:0] v, ev;
    logic [3:0]   idx_t [3];
    logic [127:0] exp_t [3];
    idx_t[0] = 4'd0;  exp_t[0] = 128'h000102030405060708090a0b0c0d0e0f;
    idx_t[1] = 4'd1;  exp_t[1] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    idx_t[2] = 4'd10; exp_t[2] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    pulse_start_a(128'h000102030405060708090a0b0c0d0e0f);
    n_checks++;
    if ({busy_a, kv_a} !== 2'b10) begin
      n_fail++; $display("FAIL f128_busy_after_start: got %b want 10", {busy_a, kv_a});
    end
    wait_done_a(n);
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL f128_latency: got %0d want %0d", n, e); end
    n_checks++;
    if ({busy_a, kv_a} !== 2'b01) begin
      n_fail++; $display("FAIL f128_flags_at_done: got %b want 01", {busy_a, kv_a});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done_a, kv_a} !== 2'b01) begin
      n_fail++; $display("FAIL f128_done_pulse: got %b want 01", {done_a, kv_a});
    end
    for (int t = 0; t < 3; t++) begin
      rk_q.push_back(exp_t[t]);
      read_a(idx_t[t], v);
      ev = rk_q.pop_front();
      n_checks++;
      if (v !== ev) begin n_fail++; $display("FAIL f128_rk%0d: got %h want %h", idx_t[t], v, ev); end
    end
  endtask

  task automatic test_decrypt();
    int n, e;
    logic [127:0] v, ev, pt;
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand({k, 128'h0}, 4);
    pulse_start_a(k);
    wait_done_a(n);
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL dec_latency: got %0d want %0d", n, e); end
    rk_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_a(4'd10, v);
    ev = rk_q.pop_front();
    n_checks++;
    if (v !== ev) begin n_fail++; $display("FAIL dec_rk10: got %h want %h", v, ev); end
    for (int r = 10; r >= 0; r--) begin
      rk_q.push_back(model_rk(r));
      read_a(4'(r), v);
      dk[r] = v;
      ev = rk_q.pop_front();
      n_checks++;
      if (v !== ev) begin n_fail++; $display("FAIL dec_sweep_rk%0d: got %h want %h", r, v, ev); end
    end
    inv_cipher(128'h3925841d02dc09fbdc118597196a0b32, pt);
    n_checks++;
    if (pt !== 128'h3243f6a8885a308d313198a2e0370734) begin
      n_fail++; $display("FAIL dec_plaintext: got %h want 3243f6a8885a308d313198a2e0370734", pt);
    end
  endtask

  task automatic test_aes256();
    int n, e;
    logic [127:0] v, ev;
    logic [3:0]   idx_t [4];
    logic [127:0] exp_t [4];
    idx_t[0] = 4'd0;  exp_t[0] = 128'h000102030405060708090a0b0c0d0e0f;
    idx_t[1] = 4'd1;  exp_t[1] = 128'h101112131415161718191a1b1c1d1e1f;
    idx_t[2] = 4'd14; exp_t[2] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    idx_t[3] = 4'd15; exp_t[3] = 128'h0;
    @(negedge clk);
    key_b = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    start_b = 1'b1;
    lat_q.push_back(52);
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL a256_latency: got %0d want %0d", n, e); end
    n_checks++;
    if (kv_b !== 1'b1) begin n_fail++; $display("FAIL a256_keys_valid: got %b want 1", kv_b); end
    for (int t = 0; t < 4; t++) begin
      rk_q.push_back(exp_t[t]);
      @(negedge clk);
      idx_b = idx_t[t];
      #1 v = rk_b;
      ev = rk_q.pop_front();
      n_checks++;
      if (v !== ev) begin n_fail++; $display("FAIL a256_rk%0d: got %h want %h", idx_t[t], v, ev); end
    end
  endtask

  task automatic test_start_while_busy();
    int n, e;
    logic [127:0] v, ev, k1;
    k1 = 128'h00112233445566778899aabbccddeeff;
    model_expand({k1, 128'h0}, 4);
    pulse_start_a(k1);
    n = 0;
    while (done_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      if (n == 4 || n == 19) begin
        start_a = 1'b1;
        key_a = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_a = 1'b0;
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL busy_start_latency: got %0d want %0d", n, e); end
    for (int r = 0; r <= 10; r++) begin
      rk_q.push_back(model_rk(r));
      read_a(4'(r), v);
      ev = rk_q.pop_front();
      n_checks++;
      if (v !== ev) begin n_fail++; $display("FAIL busy_start_rk%0d: got %h want %h", r, v, ev); end
    end
  endtask

  task automatic test_reset_mid();
    int n, e;
    logic [127:0] v, ev, k3;
    k3 = 128'hffeeddccbbaa99887766554433221100;
    idx_a = 4'd0;
    pulse_start_a(128'h0f0e0d0c0b0a09080706050403020100);
    void'(lat_q.pop_front());
    repeat (16) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, done_a, kv_a} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_ctrl: got %b want 000", {busy_a, done_a, kv_a});
    end
    n_checks++;
    if (rk_a !== 128'h0) begin n_fail++; $display("FAIL midrst_rk0: got %h want 0", rk_a); end
    @(negedge clk) rst_n = 1'b1;
    model_expand({k3, 128'h0}, 4);
    pulse_start_a(k3);
    wait_done_a(n);
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL midrst_relatency: got %0d want %0d", n, e); end
    rk_q.push_back(model_rk(10));
    read_a(4'd10, v);
    ev = rk_q.pop_front();
    n_checks++;
    if (v !== ev) begin n_fail++; $display("FAIL midrst_rk10: got %h want %h", v, ev); end
  endtask

  task automatic test_out_of_range();
    logic [127:0] v;
    n_checks++;
    if (kv_a !== 1'b1) begin n_fail++; $display("FAIL oor_keys_valid: got %b want 1", kv_a); end
    read_a(4'd15, v);
    n_checks++;
    if (v !== 128'h0) begin n_fail++; $display("FAIL oor_rk15: got %h want 0", v); end
    read_a(4'd11, v);
    n_checks++;
    if (v !== 128'h0) begin n_fail++; $display("FAIL oor_rk11: got %h want 0", v); end
  endtask

  task automatic test_start_held();
    int n, e;
    logic expd;
    @(negedge clk);
    key_a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    start_a = 1'b1;
    done_q.push_back(40); done_q.push_back(81); done_q.push_back(122);
    @(posedge clk); #1;
    for (int k = 1; k <= 125; k++) begin
      @(posedge clk); #1;
      expd = (k >= 40) && ((k - 40) % 41 == 0);
      n_checks++;
      if (done_a !== expd) begin n_fail++; $display("FAIL held_done c%0d: got %b want %b", k, done_a, expd); end
      n_checks++;
      if (kv_a !== expd) begin n_fail++; $display("FAIL held_kv c%0d: got %b want %b", k, kv_a, expd); end
      if (done_a === 1'b1 && done_q.size() > 0) begin
        e = done_q.pop_front();
        n_checks++;
        if (k !== e) begin n_fail++; $display("FAIL held_done_cycle: got %0d want %0d", k, e); end
      end
    end
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++; $display("FAIL held_missing_done: got %0d pending want 0", done_q.size());
    end
    @(negedge clk) start_a = 1'b0;
    lat_q.push_back(38);
    wait_done_a(n);
    e = lat_q.pop_front();
    n_checks++;
    if (n !== e) begin n_fail++; $display("FAIL held_tail_latency: got %0d want %0d", n, e); end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips128();
    test_decrypt();
    test_aes256();
    test_start_while_busy();
    test_reset_mid();
    test_out_of_range();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
